// File: rtl/tc_psum_col_packer.sv
// ----------------------------------------------------------------------------
// tc_psum_col_packer
//
// Producer-side packer for the column-oriented partial-sum collector. Takes
// one dense column of M partial sums plus its column index, and emits it as a
// sequence of beats. Each beat has up to NUM_OUT (row, value) lanes, which is
// the sparse col/row/in format the collector consumes. out_valid drives the
// collector's input_en directly.
//
// Optional feature macro: PSUM_PACKER_ZERO_SKIP_EN
//   defined   : only nonzero rows are sent. An all-zero column still produces
//               one beat, with mask 0, rows 0, data 0 and last set.
//   undefined : dense mode. All M rows are sent in M/NUM_OUT full beats.
//
// Ports
//   clk, rst          clock (rising edge); asynchronous active-high reset
//   in_valid/in_ready column handshake; accepted only while idle
//   in_col            column index of the offered column
//   in_data           dense column; row r at [r*DW_DATA +: DW_DATA]
//   out_valid/ready   beat handshake; all out_* are held while stalled
//   out_col           column index of the current beat
//   out_row/out_data  lane row indices / lane values, lane 0 in the LSBs
//   out_mask          lane i carries real data
//   out_last          final beat of the column
//   beat_cnt          consumed beats since reset, saturating at 0xFFFF
// ----------------------------------------------------------------------------
module tc_psum_col_packer #(
    parameter int M       = 16,
    parameter int NUM_OUT = 4,
    parameter int DW_DATA = 8,
    parameter int DW_POS  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DW_POS-1:0]            in_col,
    input  logic [M*DW_DATA-1:0]         in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DW_POS-1:0]            out_col,
    output logic [NUM_OUT*DW_POS-1:0]    out_row,
    output logic [NUM_OUT*DW_DATA-1:0]   out_data,
    output logic [NUM_OUT-1:0]           out_mask,
    output logic                         out_last,
    output logic [15:0]                  beat_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]                 r_state;
    logic [M*DW_DATA-1:0]       r_buf;        // latched column values
    logic [M-1:0]               r_pend;       // rows not yet loaded into a beat
    logic                       r_out_valid;
    logic                       r_out_last;
    logic [DW_POS-1:0]          r_out_col;
    logic [NUM_OUT*DW_POS-1:0]  r_out_row;
    logic [NUM_OUT*DW_DATA-1:0] r_out_data;
    logic [NUM_OUT-1:0]         r_out_mask;
    logic [15:0]                r_beat_cnt;

    // ------------------------------------------------------------------
    // Pending set of a freshly offered column
    // ------------------------------------------------------------------
    logic [M-1:0] w_new_pend;

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_new_pend
`ifdef PSUM_PACKER_ZERO_SKIP_EN
            assign w_new_pend[gi] = |in_data[gi*DW_DATA +: DW_DATA];
`else
            assign w_new_pend[gi] = 1'b1;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Beat builder
    //
    // There is a single packer. It sees the incoming column while idle,
    // because the first beat is registered on the acceptance edge. It sees
    // the buffered column while emitting, to build each follow-on beat.
    // ------------------------------------------------------------------
    logic [M-1:0]               w_src_pend;
    logic [M*DW_DATA-1:0]       w_src_data;
    logic [NUM_OUT*DW_POS-1:0]  w_lane_row;
    logic [NUM_OUT*DW_DATA-1:0] w_lane_data;
    logic [NUM_OUT-1:0]         w_lane_mask;
    logic [M-1:0]               w_take;
    logic [M-1:0]               w_rest;
    logic                       w_last;
    logic                       w_accept;
    logic                       w_consume;

    assign w_src_pend = (r_state == ST_IDLE) ? w_new_pend : r_pend;
    assign w_src_data = (r_state == ST_IDLE) ? in_data    : r_buf;

    always_comb begin
        int rank;
        w_lane_row  = '0;
        w_lane_data = '0;
        w_lane_mask = '0;
        w_take      = '0;
        rank        = 0;
        // A pending row's rank is the number of pending rows below it.
        // Ranks 0..NUM_OUT-1 fill lanes 0 upward, in ascending row order.
        for (int r = 0; r < M; r++) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (w_src_pend[r] && (rank == i)) begin
                    w_lane_row[i*DW_POS +: DW_POS]    = DW_POS'(r);
                    w_lane_data[i*DW_DATA +: DW_DATA] = w_src_data[r*DW_DATA +: DW_DATA];
                    w_lane_mask[i]                    = 1'b1;
                    w_take[r]                         = 1'b1;
                end
            end
            if (w_src_pend[r]) begin
                rank = rank + 1;
            end
        end
        // Unused lanes repeat the previous lane. Because the valid lanes are
        // contiguous from lane 0, this copies the last valid lane so that
        // collector writes stay idempotent. With no valid lanes, everything
        // stays at zero.
        for (int i = 1; i < NUM_OUT; i++) begin
            if (!w_lane_mask[i]) begin
                w_lane_row[i*DW_POS +: DW_POS]    = w_lane_row[(i-1)*DW_POS +: DW_POS];
                w_lane_data[i*DW_DATA +: DW_DATA] = w_lane_data[(i-1)*DW_DATA +: DW_DATA];
            end
        end
    end

    assign w_rest    = w_src_pend & ~w_take;
    assign w_last    = ~|w_rest;
    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign w_consume = (r_state == ST_EMIT) && r_out_valid && out_ready;

    // ------------------------------------------------------------------
    // Sequential control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_buf       <= '0;
            r_pend      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_col   <= '0;
            r_out_row   <= '0;
            r_out_data  <= '0;
            r_out_mask  <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_buf       <= in_data;
                r_out_col   <= in_col;
                r_out_row   <= w_lane_row;
                r_out_data  <= w_lane_data;
                r_out_mask  <= w_lane_mask;
                r_out_last  <= w_last;
                r_pend      <= w_rest;
                r_out_valid <= 1'b1;
                r_state     <= ST_EMIT;
            end

            if (w_consume) begin
                if (r_beat_cnt != 16'hFFFF) begin
                    r_beat_cnt <= r_beat_cnt + 16'd1;
                end
                if (r_out_last) begin
                    // No overlap between columns: drop valid for at least
                    // one cycle before the next column can be accepted.
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_state     <= ST_IDLE;
                end else begin
                    r_out_row   <= w_lane_row;
                    r_out_data  <= w_lane_data;
                    r_out_mask  <= w_lane_mask;
                    r_out_last  <= w_last;
                    r_pend      <= w_rest;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign out_col   = r_out_col;
    assign out_row   = r_out_row;
    assign out_data  = r_out_data;
    assign out_mask  = r_out_mask;
    assign out_last  = r_out_last;
    assign beat_cnt  = r_beat_cnt;

endmodule
